// File: rtl/sb_dcache_scheduler.sv
// Store/load arbiter for the single Dcache request port.
// One outstanding store write tracked from issue to Dcache acknowledge.
module sb_dcache_scheduler #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic        Clk,
  input  logic        Rest,
  input  logic        SchedFlash,
  input  logic        DrainForce,
  input  logic        SbReqAble,
  input  logic [2:0]  SbReqPtr,
  input  logic [1:0]  SbReqMat,
  input  logic [31:0] SbReqAddr,
  input  logic [31:0] SbReqDate,
  input  logic        SbFull,
  output logic        SbGrant,
  output logic        SbDoneAble,
  output logic [2:0]  SbDonePtr,
  input  logic        LdReqAble,
  input  logic [31:0] LdReqAddr,
  output logic        LdGrant,
  output logic        DcReqAble,
  output logic        DcReqWrite,
  output logic [1:0]  DcReqMat,
  output logic [31:0] DcReqAddr,
  output logic [31:0] DcReqDate,
  input  logic        DcReqReady,
  input  logic        DcWrAck,
  output logic        SchedIdle,
  output logic        TimeoutErr
);

  typedef enum logic [1:0] {
    IDLE,
    ST_REQ,
    ST_WAIT
  } state_t;

  typedef struct packed {
    logic [2:0]  ptr;
    logic [1:0]  mat;
    logic [31:0] addr;
    logic [31:0] data;
  } hold_t;

  localparam logic [7:0] SLIM  = STARVE_LIMIT[7:0];
  localparam logic [9:0] TLAST = 10'(TIMEOUT - 1);

  state_t      state_q, state_d;
  hold_t       hold_q, hold_d;
  logic [7:0]  starve_q, starve_d;
  logic [9:0]  tcnt_q, tcnt_d;
  logic        terr_q, terr_d;
  logic        st_sel;
  logic        ld_ok;
  logic        ld_drv;

  always_ff @(posedge Clk) begin
    if (Rest) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      starve_q <= '0;
      tcnt_q   <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      starve_q <= starve_d;
      tcnt_q   <= tcnt_d;
      terr_q   <= terr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    tcnt_d     = tcnt_q;
    terr_d     = terr_q;
    starve_d   = starve_q;
    st_sel     = 1'b0;
    ld_drv     = 1'b0;
    SbGrant    = 1'b0;
    SbDoneAble = 1'b0;
    SbDonePtr  = '0;
    LdGrant    = 1'b0;
    DcReqAble  = 1'b0;
    DcReqWrite = 1'b0;
    DcReqMat   = '0;
    DcReqAddr  = '0;
    DcReqDate  = '0;
    ld_ok      = LdReqAble && !SchedFlash;

    unique case (state_q)
      IDLE: begin
        st_sel = SbReqAble &&
                 (!LdReqAble || SchedFlash ||
                  SbFull || DrainForce ||
                  (starve_q == SLIM));
        if (st_sel) begin
          hold_d.ptr  = SbReqPtr;
          hold_d.mat  = SbReqMat;
          hold_d.addr = SbReqAddr;
          hold_d.data = SbReqDate;
          state_d     = ST_REQ;
        end else begin
          ld_drv = ld_ok;
        end
      end
      ST_REQ: begin
        DcReqAble  = 1'b1;
        DcReqWrite = 1'b1;
        DcReqMat   = hold_q.mat;
        DcReqAddr  = hold_q.addr;
        DcReqDate  = hold_q.data;
        if (DcReqReady) begin
          SbGrant = 1'b1;
          state_d = ST_WAIT;
          tcnt_d  = '0;
        end
      end
      ST_WAIT: begin
        if (DcWrAck) begin
          SbDoneAble = 1'b1;
          SbDonePtr  = hold_q.ptr;
          state_d    = IDLE;
        end else begin
          // uncached stores keep loads off the port until acked
          ld_drv = ld_ok && (hold_q.mat != 2'b00);
          if (tcnt_q == TLAST) begin
            terr_d  = 1'b1;
            state_d = IDLE;
          end else begin
            tcnt_d = tcnt_q + 10'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (ld_drv) begin
      DcReqAble = 1'b1;
      DcReqMat  = 2'b01;
      DcReqAddr = LdReqAddr;
      LdGrant   = DcReqReady;
    end

    if (st_sel || SchedFlash || !SbReqAble)
      starve_d = '0;
    else if (LdGrant && (starve_q != SLIM))
      starve_d = starve_q + 8'd1;
  end

  assign SchedIdle  = (state_q == IDLE) && !SbReqAble;
  assign TimeoutErr = terr_q;

endmodule

// File: tb/tb_sb_dcache_scheduler.sv
// Bench for sb_dcache_scheduler: directed scenarios
// plus random traffic against a transaction-level model.
module tb_sb_dcache_scheduler;

  localparam int SL = 8;
  localparam int TO = 4;

  logic        Clk = 1'b0;
  logic        Rest, SchedFlash, DrainForce;
  logic        SbReqAble, SbFull;
  logic [2:0]  SbReqPtr;
  logic [1:0]  SbReqMat;
  logic [31:0] SbReqAddr, SbReqDate;
  logic        SbGrant, SbDoneAble;
  logic [2:0]  SbDonePtr;
  logic        LdReqAble, LdGrant;
  logic [31:0] LdReqAddr;
  logic        DcReqAble, DcReqWrite;
  logic [1:0]  DcReqMat;
  logic [31:0] DcReqAddr, DcReqDate;
  logic        DcReqReady, DcWrAck;
  logic        SchedIdle, TimeoutErr;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  sb_dcache_scheduler #(
    .STARVE_LIMIT(SL),
    .TIMEOUT(TO)
  ) dut (
    .Clk(Clk), .Rest(Rest),
    .SchedFlash(SchedFlash), .DrainForce(DrainForce),
    .SbReqAble(SbReqAble), .SbReqPtr(SbReqPtr),
    .SbReqMat(SbReqMat), .SbReqAddr(SbReqAddr),
    .SbReqDate(SbReqDate), .SbFull(SbFull),
    .SbGrant(SbGrant), .SbDoneAble(SbDoneAble),
    .SbDonePtr(SbDonePtr), .LdReqAble(LdReqAble),
    .LdReqAddr(LdReqAddr), .LdGrant(LdGrant),
    .DcReqAble(DcReqAble), .DcReqWrite(DcReqWrite),
    .DcReqMat(DcReqMat), .DcReqAddr(DcReqAddr),
    .DcReqDate(DcReqDate), .DcReqReady(DcReqReady),
    .DcWrAck(DcWrAck), .SchedIdle(SchedIdle),
    .TimeoutErr(TimeoutErr)
  );

  // in-flight store: none / waiting for port / waiting for ack
  int          m_phase;
  logic [2:0]  m_ptr;
  logic [1:0]  m_mat;
  logic [31:0] m_addr, m_data;
  int          m_starve, m_waited;
  bit          m_err;
  bit          m_valid = 0;

  always @(negedge Clk) begin : model
    logic        e_sg, e_sd, e_lg, e_dv, e_dw, e_idle;
    logic [2:0]  e_dp;
    logic [1:0]  e_dm;
    logic [31:0] e_da, e_dd;
    logic [75:0] e_v, a_v;
    bit          take, load_on;
    e_sg = 0; e_sd = 0; e_lg = 0; e_dv = 0; e_dw = 0;
    e_dp = 0; e_dm = 0; e_da = 0; e_dd = 0;
    take = 0; load_on = 0;
    e_idle = (m_phase == 0) && !SbReqAble;
    if (m_phase == 0) begin
      take = SbReqAble && (!LdReqAble || SchedFlash || SbFull
             || DrainForce || m_starve == SL);
      load_on = !take && LdReqAble && !SchedFlash;
    end else if (m_phase == 1) begin
      e_dv = 1; e_dw = 1; e_dm = m_mat;
      e_da = m_addr; e_dd = m_data;
      e_sg = DcReqReady;
    end else begin
      e_sd = DcWrAck;
      e_dp = DcWrAck ? m_ptr : 3'd0;
      load_on = !DcWrAck && LdReqAble && !SchedFlash
                && m_mat != 2'b00;
    end
    if (load_on) begin
      e_dv = 1; e_dm = 2'b01; e_da = LdReqAddr;
      e_lg = DcReqReady;
    end
    if (m_valid) begin
      e_v = {e_sg, e_sd, e_dp, e_lg, e_dv, e_dw, e_dm,
             e_da, e_dd, e_idle, m_err};
      a_v = {SbGrant, SbDoneAble, SbDonePtr, LdGrant,
             DcReqAble, DcReqWrite, DcReqMat, DcReqAddr,
             DcReqDate, SchedIdle, TimeoutErr};
      checks++;
      if (a_v !== e_v) begin
        failures++;
        $display("FAIL model t=%0t got %h want %h",
                 $time, a_v, e_v);
      end
    end
    if (take || SchedFlash || !SbReqAble) m_starve = 0;
    else if (e_lg && m_starve < SL) m_starve++;
    if (m_phase == 0 && take) begin
      m_phase = 1;
      m_ptr = SbReqPtr; m_mat = SbReqMat;
      m_addr = SbReqAddr; m_data = SbReqDate;
    end else if (m_phase == 1 && DcReqReady) begin
      m_phase = 2; m_waited = 0;
    end else if (m_phase == 2) begin
      if (DcWrAck) m_phase = 0;
      else begin
        m_waited++;
        if (m_waited == TO) begin
          m_err = 1; m_phase = 0;
        end
      end
    end
    if (Rest) begin
      m_phase = 0; m_ptr = 0; m_mat = 0; m_addr = 0;
      m_data = 0; m_starve = 0; m_waited = 0; m_err = 0;
      m_valid = 1;
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    @(negedge Clk);
    #1;
  endtask

  task automatic lit(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  initial begin
    int n;
    Rest = 1; SchedFlash = 0; DrainForce = 0;
    SbReqAble = 0; SbReqPtr = 0; SbReqMat = 0;
    SbReqAddr = 0; SbReqDate = 0; SbFull = 0;
    LdReqAble = 0; LdReqAddr = 0;
    DcReqReady = 0; DcWrAck = 0;
    repeat (2) step();
    Rest = 0;
    settle();
    lit("rst_idle", 32'(SchedIdle), 1);
    lit("rst_err", 32'(TimeoutErr), 0);
    lit("rst_dv", 32'(DcReqAble), 0);

    // lone store
    step();
    SbReqAble = 1; SbReqPtr = 3; SbReqMat = 2'b01;
    SbReqAddr = 32'h1000_0040; SbReqDate = 32'hDEAD_BEEF;
    DcReqReady = 1;
    settle();
    lit("sel_no_req", 32'(DcReqAble), 0);
    step();
    SbReqAble = 0;
    settle();
    lit("st_write", 32'(DcReqWrite), 1);
    lit("st_addr", DcReqAddr, 32'h1000_0040);
    lit("st_data", DcReqDate, 32'hDEAD_BEEF);
    lit("st_grant", 32'(SbGrant), 1);
    step();
    settle();
    lit("st_nodone", 32'(SbDoneAble), 0);
    step();
    DcWrAck = 1;
    settle();
    lit("st_done", 32'(SbDoneAble), 1);
    lit("st_doneptr", 32'(SbDonePtr), 3);
    step();
    DcWrAck = 0;

    // starvation
    LdReqAble = 1; LdReqAddr = 32'h2000_0000;
    SbReqAble = 1; SbReqPtr = 5; SbReqMat = 2'b01;
    SbReqAddr = 32'h0000_3000; SbReqDate = 32'h1234;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      settle();
      if (!LdGrant) break;
      n++;
      step();
    end
    lit("starve_wins", n, SL);
    step();
    SbReqAble = 0;
    settle();
    lit("starve_st", 32'(DcReqWrite), 1);
    lit("starve_ldblk", 32'(LdGrant), 0);
    step();
    settle();
    lit("cached_ld", 32'(LdGrant), 1);
    step();
    DcWrAck = 1;
    settle();
    lit("cached_done", 32'(SbDoneAble), 1);
    lit("ack_ldblk", 32'(LdGrant), 0);
    step();
    DcWrAck = 0;

    // full override, uncached, flush
    SbReqAble = 1; SbFull = 1; SbReqPtr = 2;
    SbReqMat = 2'b00; SbReqAddr = 32'h4000;
    settle();
    lit("full_ld", 32'(LdGrant), 0);
    step();
    SbReqAble = 0; SbFull = 0;
    settle();
    lit("full_st", 32'(DcReqWrite), 1);
    step();
    settle();
    lit("uc_ld1", 32'(LdGrant), 0);
    step();
    SchedFlash = 1;
    settle();
    lit("flush_ld", 32'(LdGrant), 0);
    lit("flush_dv", 32'(DcReqAble), 0);
    step();
    SchedFlash = 0; DcWrAck = 1;
    settle();
    lit("uc_done", 32'(SbDoneAble), 1);
    lit("uc_ptr", 32'(SbDonePtr), 2);
    step();
    DcWrAck = 0;
    settle();
    lit("uc_after", 32'(LdGrant), 1);

    // drain override then timeout
    step();
    SbReqAble = 1; DrainForce = 1;
    SbReqPtr = 6; SbReqMat = 2'b01;
    settle();
    lit("drain_ld", 32'(LdGrant), 0);
    step();
    SbReqAble = 0; DrainForce = 0; LdReqAble = 0;
    settle();
    lit("drain_grant", 32'(SbGrant), 1);
    for (int k = 0; k < TO; k++) begin
      step();
      settle();
      lit("to_nodone", 32'(SbDoneAble), 0);
      lit("to_noerr", 32'(TimeoutErr), 0);
    end
    step();
    settle();
    lit("to_err", 32'(TimeoutErr), 1);
    lit("to_idle", 32'(SchedIdle), 1);
    step();
    settle();
    lit("to_sticky", 32'(TimeoutErr), 1);

    // reset in ST_REQ
    step();
    SbReqAble = 1; DcReqReady = 0;
    step();
    SbReqAble = 0;
    settle();
    lit("req_stall", 32'(DcReqAble), 1);
    step();
    Rest = 1;
    step();
    Rest = 0;
    settle();
    lit("rst_dv2", 32'(DcReqAble), 0);
    lit("rst_err2", 32'(TimeoutErr), 0);
    lit("rst_idle2", 32'(SchedIdle), 1);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      step();
      Rest       = ($urandom_range(0, 199) == 0);
      SchedFlash = ($urandom_range(0, 9) == 0);
      DrainForce = ($urandom_range(0, 9) == 0);
      SbReqAble  = ($urandom_range(0, 9) < 6);
      SbFull     = ($urandom_range(0, 19) < 3);
      SbReqPtr   = 3'($urandom_range(1, 7));
      SbReqMat   = 2'($urandom_range(0, 3));
      SbReqAddr  = $urandom;
      SbReqDate  = $urandom;
      LdReqAble  = ($urandom_range(0, 9) < 7);
      LdReqAddr  = $urandom;
      DcReqReady = ($urandom_range(0, 9) < 7);
      DcWrAck    = ($urandom_range(0, 9) < 3);
    end
    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
